// File: rtl/egress_arbiter.sv
// egress_arbiter
//   Egress side of the tdest-tagged switch fabric; one instance per physical
//   egress port. Arbitrates NUM_INGRESS ingress streams in round-robin order,
//   one whole frame at a time, and accepts only frames whose tdest equals
//   PORT_ID. Frames pass through a single registered output stage. A frame
//   whose source stalls mid-frame is terminated with an abort beat.
//
// Ports
//   clk, reset        clock, asynchronous active-high reset
//   en                permits new grants (a frame in progress always completes)
//   in_tvalid/tdata/tdest/tlast/tready
//                     per-ingress streams; lane i uses tdata[16i+:16],
//                     tdest[2i+:2]
//   out_tvalid/tdata/tlast/tready
//                     registered egress stream toward the MAC
//   out_tabort        marks an out_tlast beat as closing a truncated frame
//   timeout           one-cycle pulse when a stalled frame is aborted
//   frame_count       frames completed on the output (aborts included), wraps
module egress_arbiter #(
    parameter int unsigned NUM_INGRESS       = 4,
    parameter logic [1:0]  PORT_ID           = 2'd0,
    parameter int unsigned TIMEOUT_CTR_WIDTH = 4,
    parameter int unsigned FRAME_CTR_WIDTH   = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic [NUM_INGRESS-1:0]      in_tvalid,
    input  logic [16*NUM_INGRESS-1:0]   in_tdata,
    input  logic [2*NUM_INGRESS-1:0]    in_tdest,
    input  logic [NUM_INGRESS-1:0]      in_tlast,
    output logic [NUM_INGRESS-1:0]      in_tready,
    output logic                        out_tvalid,
    output logic [15:0]                 out_tdata,
    output logic                        out_tlast,
    output logic                        out_tabort,
    input  logic                        out_tready,
    output logic                        timeout,
    output logic [FRAME_CTR_WIDTH-1:0]  frame_count
);

    localparam int unsigned GW = $clog2(NUM_INGRESS);
    // Counter value from which one more idle cycle reaches all-ones.
    localparam logic [TIMEOUT_CTR_WIDTH-1:0] STALL_PRE_MAX = ~TIMEOUT_CTR_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        ABORT
    } state_t;

    state_t                        state;
    state_t                        next_state;
    logic [GW-1:0]                 grant;
    logic [GW-1:0]                 rr_ptr;
    logic [GW-1:0]                 pick;
    logic [GW-1:0]                 grant_inc;
    logic [TIMEOUT_CTR_WIDTH-1:0]  stall_ctr;
    logic [NUM_INGRESS-1:0]        req;
    logic                          found;
    logic                          stage_free;
    logic                          sel_valid;
    logic                          sel_last;
    logic [15:0]                   sel_data;
    logic                          do_grant;
    logic                          beat;
    logic                          abort_load;
    logic                          to_abort;

    assign stage_free = !out_tvalid || out_tready;
    assign grant_inc  = (grant == GW'(NUM_INGRESS - 1)) ? '0 : grant + 1'b1;

    always_comb begin
        req = '0;
        for (int unsigned i = 0; i < NUM_INGRESS; i++) begin
            req[i] = in_tvalid[i] && (in_tdest[2*i +: 2] == PORT_ID);
        end
    end

    // Round-robin search: first pass covers lanes at or above rr_ptr, the
    // second pass wraps around to the lanes below it.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 0; i < NUM_INGRESS; i++) begin
            if (!found && req[i] && (GW'(i) >= rr_ptr)) begin
                found = 1'b1;
                pick  = GW'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_INGRESS; i++) begin
            if (!found && req[i] && (GW'(i) < rr_ptr)) begin
                found = 1'b1;
                pick  = GW'(i);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        in_tready = '0;
        for (int unsigned i = 0; i < NUM_INGRESS; i++) begin
            if (grant == GW'(i)) begin
                sel_valid    = in_tvalid[i];
                sel_last     = in_tlast[i];
                sel_data     = in_tdata[16*i +: 16];
                in_tready[i] = (state == BUSY) && stage_free;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        do_grant   = 1'b0;
        beat       = 1'b0;
        abort_load = 1'b0;
        to_abort   = 1'b0;
        case (state)
            IDLE: begin
                if (en && found) begin
                    do_grant   = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                if (sel_valid && stage_free) begin
                    beat = 1'b1;
                    if (sel_last) begin
                        next_state = IDLE;
                    end
                end else if (!sel_valid && (stall_ctr == STALL_PRE_MAX)) begin
                    to_abort   = 1'b1;
                    next_state = ABORT;
                end
            end
            ABORT: begin
                if (stage_free) begin
                    abort_load = 1'b1;
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            grant       <= '0;
            rr_ptr      <= '0;
            stall_ctr   <= '0;
            timeout     <= 1'b0;
            out_tvalid  <= 1'b0;
            out_tdata   <= '0;
            out_tlast   <= 1'b0;
            out_tabort  <= 1'b0;
            frame_count <= '0;
        end else begin
            timeout <= to_abort;

            if (do_grant) begin
                grant <= pick;
            end

            if ((beat && sel_last) || abort_load) begin
                rr_ptr <= grant_inc;
            end

            // Backpressure with valid data pending neither counts nor clears.
            if ((state != BUSY) || beat) begin
                stall_ctr <= '0;
            end else if (!sel_valid) begin
                stall_ctr <= stall_ctr + 1'b1;
            end

            if (beat) begin
                out_tvalid <= 1'b1;
                out_tdata  <= sel_data;
                out_tlast  <= sel_last;
                out_tabort <= 1'b0;
            end else if (abort_load) begin
                out_tvalid <= 1'b1;
                out_tdata  <= 16'h0000;
                out_tlast  <= 1'b1;
                out_tabort <= 1'b1;
            end else if (out_tready) begin
                out_tvalid <= 1'b0;
            end

            if (out_tvalid && out_tready && out_tlast) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_egress_arbiter.sv
module tb_egress_arbiter;

    logic        clk;
    logic        reset;
    logic        en;
    logic [3:0]  in_tvalid;
    logic [63:0] in_tdata;
    logic [7:0]  in_tdest;
    logic [3:0]  in_tlast;
    logic [3:0]  in_tready;
    logic        out_tvalid;
    logic [15:0] out_tdata;
    logic        out_tlast;
    logic        out_tabort;
    logic        out_tready;
    logic        timeout;
    logic [15:0] frame_count;

    int unsigned tests;
    int unsigned fails;

    egress_arbiter #(
        .NUM_INGRESS(4),
        .PORT_ID(2'd0),
        .TIMEOUT_CTR_WIDTH(4),
        .FRAME_CTR_WIDTH(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .in_tvalid(in_tvalid),
        .in_tdata(in_tdata),
        .in_tdest(in_tdest),
        .in_tlast(in_tlast),
        .in_tready(in_tready),
        .out_tvalid(out_tvalid),
        .out_tdata(out_tdata),
        .out_tlast(out_tlast),
        .out_tabort(out_tabort),
        .out_tready(out_tready),
        .timeout(timeout),
        .frame_count(frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic [3:0]  tvalid;
        logic [63:0] tdata;
        logic [7:0]  tdest;
        logic [3:0]  tlast;
        logic        otr;
        logic [3:0]  exp_tready;
        logic        exp_ov;
        logic [15:0] exp_od;
        logic        exp_ol;
        logic        exp_oa;
        logic [15:0] exp_fc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic en_i, input logic [3:0] tv, input logic [63:0] td,
                                input logic [7:0] tdst, input logic [3:0] tl, input logic otr_i,
                                input logic [3:0] etr, input logic eov, input logic [15:0] eod,
                                input logic eol, input logic eoa, input logic [15:0] efc);
        vec_t v;
        v.en = en_i;       v.tvalid = tv;      v.tdata = td;
        v.tdest = tdst;    v.tlast = tl;       v.otr = otr_i;
        v.exp_tready = etr; v.exp_ov = eov;    v.exp_od = eod;
        v.exp_ol = eol;    v.exp_oa = eoa;     v.exp_fc = efc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b1;
        en = 1'b1;
        in_tvalid = '0;
        in_tdata = '0;
        in_tdest = '0;
        in_tlast = '0;
        out_tready = 1'b1;

        // Reset state
        #12;
        chk("rst out_tvalid", 32'(out_tvalid), 32'h0);
        chk("rst out_tdata", 32'(out_tdata), 32'h0);
        chk("rst out_tlast", 32'(out_tlast), 32'h0);
        chk("rst out_tabort", 32'(out_tabort), 32'h0);
        chk("rst timeout", 32'(timeout), 32'h0);
        chk("rst frame_count", 32'(frame_count), 32'h0);
        chk("rst in_tready", 32'(in_tready), 32'h0);
        reset = 1'b0;

        // Non-matching tdest on input 1: never granted
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(1, 4'b0010, 64'h0, 8'h04, 4'b0000, 1, 4'b0000, 0, 16'h0, 0, 0, 16'd0));
        // Inputs 0 and 2, 3-beat frames
        vecs.push_back(mk(1, 4'b0101, 64'h0000_C000_0000_A000, 8'h00, 4'b0000, 1, 4'b0001, 0, 16'h0, 0, 0, 16'd0));
        vecs.push_back(mk(1, 4'b0101, 64'h0000_C000_0000_A000, 8'h00, 4'b0000, 1, 4'b0001, 1, 16'hA000, 0, 0, 16'd0));
        vecs.push_back(mk(1, 4'b0101, 64'h0000_C000_0000_A001, 8'h00, 4'b0000, 1, 4'b0001, 1, 16'hA001, 0, 0, 16'd0));
        vecs.push_back(mk(1, 4'b0101, 64'h0000_C000_0000_A002, 8'h00, 4'b0001, 1, 4'b0000, 1, 16'hA002, 1, 0, 16'd0));
        vecs.push_back(mk(1, 4'b0100, 64'h0000_C000_0000_0000, 8'h00, 4'b0000, 1, 4'b0100, 0, 16'h0, 0, 0, 16'd1));
        vecs.push_back(mk(1, 4'b0100, 64'h0000_C000_0000_0000, 8'h00, 4'b0000, 1, 4'b0100, 1, 16'hC000, 0, 0, 16'd1));
        vecs.push_back(mk(1, 4'b0100, 64'h0000_C001_0000_0000, 8'h00, 4'b0000, 1, 4'b0100, 1, 16'hC001, 0, 0, 16'd1));
        vecs.push_back(mk(1, 4'b0100, 64'h0000_C002_0000_0000, 8'h00, 4'b0100, 1, 4'b0000, 1, 16'hC002, 1, 0, 16'd1));
        vecs.push_back(mk(1, 4'b0000, 64'h0, 8'h00, 4'b0000, 1, 4'b0000, 0, 16'h0, 0, 0, 16'd2));
        // rr_ptr is now 3: inputs 0 and 3 compete, 3 wins, then 0
        vecs.push_back(mk(1, 4'b1001, 64'hD000_0000_0000_B000, 8'h00, 4'b1001, 1, 4'b1000, 0, 16'h0, 0, 0, 16'd2));
        vecs.push_back(mk(1, 4'b1001, 64'hD000_0000_0000_B000, 8'h00, 4'b1001, 1, 4'b0000, 1, 16'hD000, 1, 0, 16'd2));
        vecs.push_back(mk(1, 4'b0001, 64'hD000_0000_0000_B000, 8'h00, 4'b1001, 1, 4'b0001, 0, 16'h0, 0, 0, 16'd3));
        vecs.push_back(mk(1, 4'b0001, 64'hD000_0000_0000_B000, 8'h00, 4'b1001, 1, 4'b0000, 1, 16'hB000, 1, 0, 16'd3));
        vecs.push_back(mk(1, 4'b0000, 64'h0, 8'h00, 4'b0000, 1, 4'b0000, 0, 16'h0, 0, 0, 16'd4));
        // en low blocks grant; rr_ptr=1 wraps to input 0
        vecs.push_back(mk(0, 4'b0001, 64'h0000_0000_0000_E000, 8'h00, 4'b0001, 1, 4'b0000, 0, 16'h0, 0, 0, 16'd4));
        vecs.push_back(mk(0, 4'b0001, 64'h0000_0000_0000_E000, 8'h00, 4'b0001, 1, 4'b0000, 0, 16'h0, 0, 0, 16'd4));
        vecs.push_back(mk(1, 4'b0001, 64'h0000_0000_0000_E000, 8'h00, 4'b0001, 1, 4'b0001, 0, 16'h0, 0, 0, 16'd4));
        vecs.push_back(mk(1, 4'b0001, 64'h0000_0000_0000_E000, 8'h00, 4'b0001, 1, 4'b0000, 1, 16'hE000, 1, 0, 16'd4));
        vecs.push_back(mk(1, 4'b0000, 64'h0, 8'h00, 4'b0000, 1, 4'b0000, 0, 16'h0, 0, 0, 16'd5));
        // en dropped mid-frame: frame still completes
        vecs.push_back(mk(1, 4'b0001, 64'h0000_0000_0000_E100, 8'h00, 4'b0000, 1, 4'b0001, 0, 16'h0, 0, 0, 16'd5));
        vecs.push_back(mk(0, 4'b0001, 64'h0000_0000_0000_E100, 8'h00, 4'b0000, 1, 4'b0001, 1, 16'hE100, 0, 0, 16'd5));
        vecs.push_back(mk(0, 4'b0001, 64'h0000_0000_0000_E101, 8'h00, 4'b0001, 1, 4'b0000, 1, 16'hE101, 1, 0, 16'd5));
        vecs.push_back(mk(0, 4'b0000, 64'h0, 8'h00, 4'b0000, 1, 4'b0000, 0, 16'h0, 0, 0, 16'd6));

        foreach (vecs[i]) begin
            en = vecs[i].en;
            in_tvalid = vecs[i].tvalid;
            in_tdata = vecs[i].tdata;
            in_tdest = vecs[i].tdest;
            in_tlast = vecs[i].tlast;
            out_tready = vecs[i].otr;
            step();
            chk($sformatf("v%0d in_tready", i), 32'(in_tready), 32'(vecs[i].exp_tready));
            chk($sformatf("v%0d out_tvalid", i), 32'(out_tvalid), 32'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) begin
                chk($sformatf("v%0d out_tdata", i), 32'(out_tdata), 32'(vecs[i].exp_od));
                chk($sformatf("v%0d out_tlast", i), 32'(out_tlast), 32'(vecs[i].exp_ol));
                chk($sformatf("v%0d out_tabort", i), 32'(out_tabort), 32'(vecs[i].exp_oa));
            end
            chk($sformatf("v%0d timeout", i), 32'(timeout), 32'h0);
            chk($sformatf("v%0d frame_count", i), 32'(frame_count), 32'(vecs[i].exp_fc));
        end

        // Backpressure: input 1 (rr_ptr=1), out_tready low 20 cycles mid-frame
        en = 1'b1;
        in_tdest = 8'h00;
        in_tvalid = 4'b0010;
        in_tdata = 64'h0000_0000_5000_0000;
        in_tlast = 4'b0000;
        out_tready = 1'b1;
        step();
        chk("bp grant tready", 32'(in_tready), 32'h2);
        step();
        chk("bp beat0 data", 32'(out_tdata), 32'h5000);
        in_tdata = 64'h0000_0000_5001_0000;
        out_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("bp hold%0d valid", i), 32'(out_tvalid), 32'h1);
            chk($sformatf("bp hold%0d data", i), 32'(out_tdata), 32'h5000);
            chk($sformatf("bp hold%0d tready", i), 32'(in_tready), 32'h0);
            chk($sformatf("bp hold%0d timeout", i), 32'(timeout), 32'h0);
        end
        out_tready = 1'b1;
        step();
        chk("bp beat1 data", 32'(out_tdata), 32'h5001);
        chk("bp beat1 last", 32'(out_tlast), 32'h0);
        in_tdata = 64'h0000_0000_5002_0000;
        in_tlast = 4'b0010;
        step();
        chk("bp beat2 data", 32'(out_tdata), 32'h5002);
        chk("bp beat2 last", 32'(out_tlast), 32'h1);
        in_tvalid = 4'b0000;
        in_tlast = 4'b0000;
        step();
        chk("bp end valid", 32'(out_tvalid), 32'h0);
        chk("bp end frame_count", 32'(frame_count), 32'd7);

        // Stall timeout: input 3 (rr_ptr=2) sends 2 beats then goes idle
        in_tvalid = 4'b1000;
        in_tdata = 64'hD100_0000_0000_0000;
        step();
        chk("to grant tready", 32'(in_tready), 32'h8);
        step();
        chk("to beat0 data", 32'(out_tdata), 32'hD100);
        in_tdata = 64'hD101_0000_0000_0000;
        step();
        chk("to beat1 data", 32'(out_tdata), 32'hD101);
        in_tvalid = 4'b0000;
        for (int i = 1; i <= 15; i++) begin
            step();
            chk($sformatf("to idle%0d timeout", i), 32'(timeout), 32'(i == 15));
        end
        chk("to abort tready", 32'(in_tready), 32'h0);
        chk("to abort no beat yet", 32'(out_tvalid), 32'h0);
        step();
        chk("to pulse ends", 32'(timeout), 32'h0);
        chk("to abort valid", 32'(out_tvalid), 32'h1);
        chk("to abort data", 32'(out_tdata), 32'h0000);
        chk("to abort last", 32'(out_tlast), 32'h1);
        chk("to abort flag", 32'(out_tabort), 32'h1);
        step();
        chk("to abort consumed", 32'(out_tvalid), 32'h0);
        chk("to frame_count", 32'(frame_count), 32'd8);

        // Round robin, all inputs with continuous 1-beat frames (rr_ptr=0)
        in_tvalid = 4'b1111;
        in_tlast = 4'b1111;
        in_tdata = 64'h1003_1002_1001_1000;
        for (int k = 0; k < 5; k++) begin
            step();
            chk($sformatf("rr%0d grant", k), 32'(in_tready), 32'(1 << (k % 4)));
            chk($sformatf("rr%0d gap", k), 32'(out_tvalid), 32'h0);
            chk($sformatf("rr%0d frame_count", k), 32'(frame_count), 32'(8 + k));
            step();
            chk($sformatf("rr%0d data", k), 32'(out_tdata), 32'(16'h1000 + (k % 4)));
            chk($sformatf("rr%0d valid", k), 32'(out_tvalid), 32'h1);
            chk($sformatf("rr%0d last", k), 32'(out_tlast), 32'h1);
        end
        in_tvalid = 4'b0000;
        in_tlast = 4'b0000;
        step();
        chk("rr end frame_count", 32'(frame_count), 32'd13);

        // Asynchronous reset mid-frame (rr_ptr=1 beforehand)
        in_tvalid = 4'b0001;
        in_tdata = 64'h0000_0000_0000_7000;
        step();
        step();
        chk("ar pre valid", 32'(out_tvalid), 32'h1);
        #3;
        reset = 1'b1;
        #1;
        chk("ar out_tvalid", 32'(out_tvalid), 32'h0);
        chk("ar out_tdata", 32'(out_tdata), 32'h0);
        chk("ar out_tlast", 32'(out_tlast), 32'h0);
        chk("ar frame_count", 32'(frame_count), 32'h0);
        chk("ar in_tready", 32'(in_tready), 32'h0);
        #2;
        reset = 1'b0;
        in_tvalid = 4'b1001;
        in_tlast = 4'b0000;
        step();
        chk("ar first grant", 32'(in_tready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
